// File: rtl/sm_xbee_msg_tx.sv
// Queued Xbee message transmitter: requests are validated into a small FIFO, expanded
// to their ASCII strings and sent as back-to-back 8N1/8N2 UART frames on tx.
`timescale 1ns/1ps
module sm_xbee_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 2,
  parameter int DEPTH        = 4
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               msg_type,
  input  logic [1:0]               field,
  input  logic [1:0]               node_si,
  input  logic [1:0]               color,
  output logic                     tx,
  output logic                     busy,
  output logic                     msg_done,
  output logic                     req_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  // state | meaning
  // IDLE  | line high, waiting for a queued request
  // START | start bit of the current character
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit(s); the last one also advances char/message (no gap cycle)
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  cnt_next;
  logic [7:0]       cur;
  logic [3:0]       char_idx, last_idx;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [CW-1:0]    clk_cnt;
  logic             done_d;
  logic             accept, req_ok, push, pop;
  logic             bit_end, frame_end, msg_last, line;
  logic [7:0]       char_c, f_chr, n_chr, c_chr;

  always_comb begin
    accept    = req_valid && req_ready;
    req_ok    = (msg_type == 2'd0) || (node_si != 2'd0 && color != 2'd0);
    push      = accept && req_ok;
    bit_end   = (clk_cnt == '0);
    frame_end = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
    case (cur[7:6])
      2'd0:    last_idx = 4'd3;
      2'd1:    last_idx = 4'd11;
      default: last_idx = 4'd12;
    endcase
    msg_last  = (char_idx == last_idx);
    pop       = (fifo_count != '0) && ((state == IDLE) || (frame_end && msg_last));
    case ({push, pop})
      2'b10:   cnt_next = fifo_count + CNTW'(1);
      2'b01:   cnt_next = fifo_count - CNTW'(1);
      default: cnt_next = fifo_count;
    endcase
  end

  // Character lookup from the latched entry {type, field, node, color}
  always_comb begin
    case (cur[5:4])
      2'd0:    f_chr = "M";
      2'd1:    f_chr = "P";
      2'd2:    f_chr = "N";
      default: f_chr = "V";
    endcase
    n_chr = 8'h30 | {6'd0, cur[3:2]};
    case (cur[1:0])
      2'd1:    c_chr = "P";
      2'd2:    c_chr = "W";
      default: c_chr = "N";
    endcase
    char_c = 8'h0A;
    if (cur[7:6] == 2'd0) begin
      case (char_idx)
        4'd0:    char_c = "E";
        4'd1:    char_c = "-";
        4'd2:    char_c = "#";
        default: char_c = 8'h0A;
      endcase
    end else if (cur[7:6] == 2'd1) begin
      case (char_idx)
        4'd0, 4'd3:       char_c = "S";
        4'd1, 4'd4:       char_c = "I";
        4'd2, 4'd7, 4'd9: char_c = "-";
        4'd5:             char_c = f_chr;
        4'd6:             char_c = n_chr;
        4'd8:             char_c = c_chr;
        4'd10:            char_c = "#";
        default:          char_c = 8'h0A;
      endcase
    end else begin
      case (char_idx)
        4'd0:                     char_c = "S";
        4'd1, 4'd3, 4'd8, 4'd10:  char_c = "-";
        4'd2:                     char_c = (cur[7:6] == 2'd2) ? "P" : "D";
        4'd4:                     char_c = "D";
        4'd5:                     char_c = "Z";
        4'd6:                     char_c = f_chr;
        4'd7:                     char_c = n_chr;
        4'd9:                     char_c = c_chr;
        4'd11:                    char_c = "#";
        default:                  char_c = 8'h0A;
      endcase
    end
    case (state)
      START:   line = 1'b0;
      DATA:    line = char_c[bit_idx];
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr] <= {msg_type, field, node_si, color};
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      req_ready  <= 1'b1;
      req_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= cnt_next;
      req_ready  <= (cnt_next != CNTW'(DEPTH));
      req_err    <= accept && !req_ok;
    end
  end

  // tx and msg_done trail the state register by one cycle, giving the k+2 start latency
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      clk_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      msg_done <= 1'b0;
      done_d   <= 1'b0;
    end else begin
      tx       <= line;
      msg_done <= done_d;
      done_d   <= 1'b0;
      busy     <= (fifo_count != '0) ||
                  ((state != IDLE) && !(frame_end && msg_last));
      case (state)
        IDLE: begin
          if (pop) begin
            cur      <= mem[rd_ptr];
            char_idx <= '0;
            clk_cnt  <= BIT_LAST;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= BIT_LAST;
            bit_idx <= '0;
            state   <= DATA;
          end else clk_cnt <= clk_cnt - CW'(1);
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              state    <= STOP;
            end else bit_idx <= bit_idx + 3'd1;
          end else clk_cnt <= clk_cnt - CW'(1);
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= BIT_LAST;
            if (!frame_end) stop_idx <= stop_idx + 1'b1;
            else if (!msg_last) begin
              char_idx <= char_idx + 4'd1;
              state    <= START;
            end else begin
              done_d <= 1'b1;
              if (pop) begin
                cur      <= mem[rd_ptr];
                char_idx <= '0;
                state    <= START;
              end else state <= IDLE;
            end
          end else clk_cnt <= clk_cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
